// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin data-memory arbiter with post-reset init sweep
module data_mem_arbiter #(
  parameter int unsigned           DataWidth = 8,
  parameter int unsigned           AddrWidth = 8,
  parameter int unsigned           DataLen   = 256,
  parameter logic [DataWidth-1:0]  InitValue = '0
) (
  input  logic                 clk_i,
  input  logic                 nReset_i,
  input  logic                 req0_i,
  input  logic                 req1_i,
  input  logic                 we0_i,
  input  logic                 we1_i,
  input  logic [AddrWidth-1:0] addr0_i,
  input  logic [AddrWidth-1:0] addr1_i,
  input  logic [DataWidth-1:0] wdata0_i,
  input  logic [DataWidth-1:0] wdata1_i,
  output logic                 gnt0_o,
  output logic                 gnt1_o,
  output logic                 rvalid0_o,
  output logic                 rvalid1_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 busy_o,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic [DataWidth-1:0] mem_rdata_i
);

  typedef enum logic {StInit, StRun} state_e;

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(DataLen - 1);

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] init_addr_q, init_addr_d;
  logic                 rr_ptr_q, rr_ptr_d;
  logic                 rvalid0_q, rvalid0_d;
  logic                 rvalid1_q, rvalid1_d;
  logic                 run;
  logic                 sweeping;

  // Reset is sampled synchronously but still gates everything combinationally,
  // so nothing reaches the memory while nReset is held low.
  assign run      = nReset_i && (state_q == StRun);
  assign sweeping = nReset_i && (state_q == StInit);

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (run) begin
      if (req0_i && (!req1_i || !rr_ptr_q)) begin
        gnt0_o = 1'b1;
      end else if (req1_i) begin
        gnt1_o = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (sweeping) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = init_addr_q;
      mem_wdata_o = InitValue;
    end else if (gnt0_o) begin
      mem_en_o    = 1'b1;
      mem_we_o    = we0_i;
      mem_addr_o  = addr0_i;
      mem_wdata_o = wdata0_i;
    end else if (gnt1_o) begin
      mem_en_o    = 1'b1;
      mem_we_o    = we1_i;
      mem_addr_o  = addr1_i;
      mem_wdata_o = wdata1_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    rr_ptr_d    = rr_ptr_q;
    rvalid0_d   = gnt0_o && !we0_i;
    rvalid1_d   = gnt1_o && !we1_i;
    case (state_q)
      StInit: begin
        init_addr_d = init_addr_q + AddrWidth'(1);
        if (init_addr_q == LastAddr) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // The requester just served loses priority on the next contention.
        if (gnt0_o) begin
          rr_ptr_d = 1'b1;
        end else if (gnt1_o) begin
          rr_ptr_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!nReset_i) begin
      state_q     <= StInit;
      init_addr_q <= '0;
      rr_ptr_q    <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      rr_ptr_q    <= rr_ptr_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
    end
  end

  assign rvalid0_o = rvalid0_q;
  assign rvalid1_o = rvalid1_q;
  assign rdata_o   = mem_rdata_i;
  assign busy_o    = !nReset_i || (state_q == StInit);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter
module tb_data_mem_arbiter;

  localparam int         DL = 256;
  localparam logic [7:0] IV = 8'h09;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy, mem_en, mem_we;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .DataWidth(8), .AddrWidth(8), .DataLen(DL), .InitValue(IV)
  ) dut (
    .clk_i(clk), .nReset_i(nReset),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rdata_o(rdata), .busy_o(busy), .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Synchronous single-port RAM with 1-cycle read latency.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct {
    int         who;
    logic [7:0] data;
    int         due;
  } rd_t;

  rd_t        sb[$];
  logic [7:0] exp_mem [256];
  int         init_left = DL;
  int         favour = 0;
  int         last_win = -1;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  bit         mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    int         win;
    logic       w;
    logic [7:0] a, d;
    last_win = -1;
    if (!nReset) begin
      chk("busy_rst", busy, 1);
      chk("gnt0_rst", gnt0, 0);
      chk("gnt1_rst", gnt1, 0);
      chk("mem_en_rst", mem_en, 0);
    end else if (init_left > 0) begin
      chk("busy_init", busy, 1);
      chk("gnt0_init", gnt0, 0);
      chk("gnt1_init", gnt1, 0);
      chk("mem_en_init", mem_en, 1);
      chk("mem_we_init", mem_we, 1);
      chk("mem_addr_init", mem_addr, DL - init_left);
      chk("mem_wdata_init", mem_wdata, IV);
      exp_mem[DL - init_left] = IV;
      init_left--;
    end else begin
      chk("busy_run", busy, 0);
      win = -1;
      if (req0 && req1) win = favour;
      else if (req0)    win = 0;
      else if (req1)    win = 1;
      chk("gnt0", gnt0, (win == 0));
      chk("gnt1", gnt1, (win == 1));
      chk("mem_en", mem_en, (win >= 0));
      if (win >= 0) begin
        last_win = win;
        favour = 1 - win;
        w = (win == 0) ? we0 : we1;
        a = (win == 0) ? addr0 : addr1;
        d = (win == 0) ? wdata0 : wdata1;
        chk("mem_we", mem_we, w);
        chk("mem_addr", mem_addr, a);
        if (w) begin
          chk("mem_wdata", mem_wdata, d);
          exp_mem[a] = d;
        end else begin
          sb.push_back('{win, exp_mem[a], cyc + 1});
        end
      end else begin
        chk("mem_we_idle", mem_we, 0);
      end
    end
  endtask

  task automatic do_cycle(input bit drop_rst = 1'b0);
    @(negedge clk);
    check_cycle();
    if (drop_rst) nReset = 1'b0;
    @(posedge clk);
    #1;
    if (!nReset) begin
      init_left = DL;
      favour = 0;
      sb.delete();
    end
    cyc++;
  endtask

  // Read-return monitor: pops the expectation due this cycle, if any.
  always @(negedge clk) begin
    int         who;
    logic [7:0] d;
    if (mon_on) begin
      who = -1;
      d = '0;
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        who = sb[0].who;
        d = sb[0].data;
        void'(sb.pop_front());
      end
      chk("rvalid0", rvalid0, (who == 0));
      chk("rvalid1", rvalid1, (who == 1));
      if (who >= 0) chk("rdata", rdata, d);
    end
  end

  initial begin
    bit p0, p1;
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    repeat (3) do_cycle();

    // Core read held through the whole sweep.
    nReset = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    repeat (DL) do_cycle();
    do_cycle();

    we0 = 1'b1; wdata0 = 8'hA5;
    do_cycle();
    we0 = 1'b0;
    do_cycle();
    req0 = 1'b0;
    do_cycle();

    // Reset lands on the edge closing a granted read.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    do_cycle(1'b1);
    nReset = 1'b1;
    req0 = 1'b0;
    repeat (DL) do_cycle();

    req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr0 = 8'h10; addr1 = 8'h20;
    repeat (6) do_cycle();
    req0 = 1'b0;
    repeat (4) do_cycle();
    req0 = 1'b1;
    do_cycle();
    req0 = 1'b0; req1 = 1'b0;
    do_cycle();

    p0 = 1'b0;
    p1 = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1'b1; we0 = 1'($urandom_range(0, 1));
        addr0 = 8'($urandom_range(0, 15)); wdata0 = 8'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1; we1 = 1'($urandom_range(0, 1));
        addr1 = 8'($urandom_range(0, 15)); wdata1 = 8'($urandom);
      end
      req0 = p0;
      req1 = p1;
      if (i == 1000) begin
        do_cycle(1'b1);
        nReset = 1'b1;
      end else begin
        do_cycle();
      end
      if (last_win == 0) p0 = 1'b0;
      if (last_win == 1) p1 = 1'b0;
    end

    req0 = 1'b0; req1 = 1'b0;
    repeat (2) do_cycle();
    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and initialisation sequencer for the processor's single-port data memory. It shares the memory port between the core (requester 0) and the debug/loader port (requester 1) with round-robin fairness. After every reset it fills the whole memory with a known value before granting any access. It sits between the two requesters and the synchronous data-memory array, which has 1-cycle read latency.

## Interface
Parameters:
- DataWidth, 8, data bus width.
- AddrWidth, 8, address width.
- DataLen, 256, number of memory words to initialise; must be ≤ 2^AddrWidth.
- InitValue, 0, value written to every word during the init sweep.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- nReset  input  1  reset nReset, synchronous, active-low.
- req0, req1  input  1  access request from core / debug port.
- we0, we1  input  1  1 = write, 0 = read; qualified by reqN.
- addr0, addr1  input  AddrWidth  access address.
- wdata0, wdata1  input  DataWidth  write data.
- gnt0, gnt1  output  1  combinational grant; the access is performed in this cycle.
- rvalid0, rvalid1  output  1  registered; read data valid for requester N.
- rdata  output  DataWidth  read data, shared by both requesters; qualified by rvalidN.
- busy  output  1  high during reset and the init sweep.
- mem_en  output  1  memory port enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  AddrWidth  memory address.
- mem_wdata  output  DataWidth  memory write data.
- mem_rdata  input  DataWidth  memory read data, valid the cycle after a read is enabled.

## Operation
- FSM states: INIT, RUN.
- Reset (nReset low at an edge):
  - state←INIT, init_addr←0, rr_ptr←0 (core has priority), rvalid0/1←0.
  - While nReset is low: gnt0/1=0, mem_en=0, busy=1.
- INIT:
  - mem_en=1, mem_we=1, mem_addr=init_addr, mem_wdata=InitValue, busy=1, gnt0/1=0.
  - init_addr increments each cycle.
  - In the cycle where init_addr==DataLen-1, the last word is written; state←RUN at that edge.
  - Requests are ignored and not lost: requesters hold reqN until granted.
- RUN:
  - busy=0.
  - Only one request active: grant it.
  - Both active: grant the requester selected by rr_ptr.
  - On any grant to N, rr_ptr←the other requester at the edge.
  - On the granted cycle: mem_en=1, mem_we=weN, mem_addr=addrN, mem_wdata=wdataN.
  - No request: mem_en=0, mem_we=0; rr_ptr is unchanged.
- Read return: a granted read sets rvalidN=1 in the next cycle, with rdata=mem_rdata. A granted write does not assert rvalid.
- A requester holding req continuously while the other is idle is granted every cycle (back-to-back).
- gnt0 and gnt1 are never high together. rvalid0 and rvalid1 are never high together.
- Reset in RUN or mid-INIT: return to INIT and restart at address 0. Any pending rvalid is cleared and not delivered.

## Timing
- Init sweep: exactly DataLen cycles from the first cycle after nReset is sampled high. busy falls in cycle DataLen+1 after reset release.
- Grant latency: 0 cycles (gnt combinational from reqN, state and rr_ptr).
- Read latency: 1 cycle from grant to rvalid/rdata.
- Throughput: one access per cycle total. Under continuous contention each requester gets every other cycle.
- mem_* outputs and gnt are combinational. rvalid, rr_ptr, state and init_addr are registered.
- rdata is a direct pass-through of mem_rdata. It is qualified only by rvalid; its value when rvalid=0 is don't-care.

## Test plan
- Reset release with DataLen=256, InitValue=8'h09:
  - busy=1 for exactly 256 cycles.
  - mem_addr sweeps 0..255 with mem_we=1 and mem_wdata=8'h09.
  - busy=0 in the next cycle.
- Core write of 8'hA5 to 8'h10, then core read of 8'h10:
  - gnt0 in both cycles.
  - rvalid0=1 with rdata=8'hA5 one cycle after the read grant.
- req0 and req1 both held high for 6 cycles in RUN, from reset state: grants alternate gnt0, gnt1, gnt0, gnt1, gnt0, gnt1.
- Only req1 held for 4 cycles: gnt1 on all 4 cycles. Then raise req0 with req1: gnt0 is granted next.
- req0 asserted during INIT: no grant until busy=0. gnt0 is given in the first RUN cycle.
- nReset pulsed low for 1 cycle while a read is granted: rvalid stays 0, init restarts at address 0, and busy=1 again.
